// File: rtl/cond_pkg.sv
// Package for the condition/flag stage.
// Holds the ARM cond-field encodings, NZCV bit positions and FlagW bit positions.
// Optional feature macro used by importers: COND_BYPASS_EN.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the NZCV nibble
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Bit positions inside FlagW
  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Interface between the controller and the condition/flag stage.
// master: controller side (drives requests, ALU flags, cond field).
// slave : cond_logic side (drives gated enables, Flags, CondEx).
interface cond_logic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       CondLatch;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  modport master (
    output Cond, ALUFlags, FlagW, CondLatch, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, CondLatch, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx
  );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition decoder.
// Ports: i_cond  - 4-bit cond field
//        i_nzcv  - flags {N,Z,C,V} to evaluate against
//        o_cond_ok - 1 when the instruction should execute
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_cond_ok
);

  logic w_n, w_z, w_c, w_v;
  assign w_n = i_nzcv[FLAG_N];
  assign w_z = i_nzcv[FLAG_Z];
  assign w_c = i_nzcv[FLAG_C];
  assign w_v = i_nzcv[FLAG_V];

  always_comb begin
    o_cond_ok = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ok = w_z;
      COND_NE: o_cond_ok = ~w_z;
      COND_CS: o_cond_ok = w_c;
      COND_CC: o_cond_ok = ~w_c;
      COND_MI: o_cond_ok = w_n;
      COND_PL: o_cond_ok = ~w_n;
      COND_VS: o_cond_ok = w_v;
      COND_VC: o_cond_ok = ~w_v;
      COND_HI: o_cond_ok = w_c & ~w_z;
      COND_LS: o_cond_ok = ~w_c | w_z;
      COND_GE: o_cond_ok = (w_n == w_v);
      COND_LT: o_cond_ok = (w_n != w_v);
      COND_GT: o_cond_ok = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ok = w_z | (w_n != w_v);
      COND_AL: o_cond_ok = 1'b1;
      default: o_cond_ok = 1'b0;  // NV never executes
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Condition/flag stage downstream of the ALU in the multicycle ARM core.
// Holds the NZCV register, latches the per-instruction condition result and gates
// the controller's PC/register/memory write enables.
// Ports: clk     - clock, rising edge
//        reset_n - asynchronous active-low reset
//        bus     - cond_logic_if.slave (Cond, ALUFlags, FlagW, CondLatch, PCS, NextPC,
//                  RegW, MemW in; PCWrite, RegWrite, MemWrite, Flags, CondEx out)
// Optional feature: COND_BYPASS_EN forwards ALUFlags being written into the condition
// evaluation (for back-to-back compare + conditional in pipelined builds).
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic         clk,
  input logic         reset_n,
  cond_logic_if.slave bus
);

  logic [3:0] r_flags;
  logic       r_cond_ex;
  logic [3:0] w_flags_src;
  logic       w_cond_ok;
  logic       w_cond_eff;

`ifdef COND_BYPASS_EN
  // Forward nibbles the previous (executing) instruction is writing this cycle.
  always_comb begin
    w_flags_src = r_flags;
    if (r_cond_ex) begin
      if (bus.FlagW[FLAGW_NZ]) w_flags_src[FLAG_N:FLAG_Z] = bus.ALUFlags[FLAG_N:FLAG_Z];
      if (bus.FlagW[FLAGW_CV]) w_flags_src[FLAG_C:FLAG_V] = bus.ALUFlags[FLAG_C:FLAG_V];
    end
  end
`else
  assign w_flags_src = r_flags;
`endif

  cond_check u_cond_check (
    .i_cond    (bus.Cond),
    .i_nzcv    (w_flags_src),
    .o_cond_ok (w_cond_ok)
  );

  // Bypass on the latch cycle so the enables see the result with zero latency.
  // Qualified by reset_n so enables drop immediately while reset is held.
  assign w_cond_eff = reset_n & (bus.CondLatch ? w_cond_ok : r_cond_ex);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags   <= RESET_FLAGS;
      r_cond_ex <= 1'b0;
    end else begin
      if (bus.CondLatch) r_cond_ex <= w_cond_ok;
      if (bus.FlagW[FLAGW_NZ] && w_cond_eff) begin
        r_flags[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      end
      if (bus.FlagW[FLAGW_CV] && w_cond_eff) begin
        r_flags[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
      end
    end
  end

  assign bus.PCWrite  = bus.NextPC | (bus.PCS & w_cond_eff);
  assign bus.RegWrite = bus.RegW & w_cond_eff;
  assign bus.MemWrite = bus.MemW & w_cond_eff;
  assign bus.Flags    = r_flags;
  assign bus.CondEx   = r_cond_ex;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed vectors with hand-computed expectations,
// plus an exhaustive cond_check table against an independently formulated reference.
module tb_cond_logic;
  import cond_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cond_logic_if bus ();

  cond_logic #(.RESET_FLAGS(4'b0000)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [3:0] chk_cond;
  logic [3:0] chk_nzcv;
  logic       chk_ok;

  cond_check u_chk (
    .i_cond    (chk_cond),
    .i_nzcv    (chk_nzcv),
    .o_cond_ok (chk_ok)
  );

  // ARM-style reference: base test from cond[3:1], inverted by cond[0]; NV forced to 0.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return base ^ c[0];
  endfunction

  task automatic idle_inputs();
    bus.Cond = 4'b0; bus.ALUFlags = 4'b0; bus.FlagW = 2'b0; bus.CondLatch = 1'b0;
    bus.PCS = 1'b0; bus.NextPC = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
  endtask

  task automatic test_reset();
    // Preload Flags=1111 and CondEx=1 with an AL flag-writing instruction
    @(negedge clk);
    idle_inputs();
    bus.CondLatch = 1'b1; bus.Cond = COND_AL; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
    @(posedge clk); #1;
    n_checks++;
    if (bus.Flags !== 4'b1111) begin
      n_fail++; $display("FAIL preload_flags: got %b want 1111", bus.Flags);
    end
    idle_inputs();
    bus.RegW = 1'b1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.Flags !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", bus.Flags);
    end
    n_checks++;
    if (bus.CondEx !== 1'b0) begin
      n_fail++; $display("FAIL reset_condex: got %b want 0", bus.CondEx);
    end
    n_checks++;
    if (bus.RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_cond_eq();
    // Set Z=1 (Flags 0100) with AL + FlagW=10
    @(negedge clk);
    idle_inputs();
    bus.CondLatch = 1'b1; bus.Cond = COND_AL; bus.FlagW = 2'b10; bus.ALUFlags = 4'b0100;
    @(posedge clk); #1;
    n_checks++;
    if (bus.Flags !== 4'b0100) begin
      n_fail++; $display("FAIL eq_setup_flags: got %b want 0100", bus.Flags);
    end
    // Latch NV to clear CondEx
    @(negedge clk);
    idle_inputs();
    bus.CondLatch = 1'b1; bus.Cond = COND_NV;
    @(posedge clk); #1;
    n_checks++;
    if (bus.CondEx !== 1'b0) begin
      n_fail++; $display("FAIL nv_condex: got %b want 0", bus.CondEx);
    end
    @(negedge clk);
    idle_inputs();
    bus.CondLatch = 1'b1; bus.Cond = COND_EQ; bus.RegW = 1'b1;
    #1;
    n_checks++;
    if (bus.RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL eq_regwrite_same_cycle: got %b want 1", bus.RegWrite);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.CondEx !== 1'b1) begin
      n_fail++; $display("FAIL eq_condex_after_edge: got %b want 1", bus.CondEx);
    end
    // Later controller state: enable comes from the held CondEx
    @(negedge clk);
    idle_inputs();
    bus.RegW = 1'b1;
    #1;
    n_checks++;
    if (bus.RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL eq_regwrite_held: got %b want 1", bus.RegWrite);
    end
  endtask

  task automatic test_cond_fail();
    @(negedge clk);
    idle_inputs();
    bus.CondLatch = 1'b1; bus.Cond = COND_NE; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0000;
    bus.RegW = 1'b1; bus.MemW = 1'b1;
    #1;
    n_checks++;
    if (bus.RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL ne_regwrite: got %b want 0", bus.RegWrite);
    end
    n_checks++;
    if (bus.MemWrite !== 1'b0) begin
      n_fail++; $display("FAIL ne_memwrite: got %b want 0", bus.MemWrite);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.Flags !== 4'b0100) begin
      n_fail++; $display("FAIL ne_flags_unchanged: got %b want 0100", bus.Flags);
    end
    n_checks++;
    if (bus.CondEx !== 1'b0) begin
      n_fail++; $display("FAIL ne_condex: got %b want 0", bus.CondEx);
    end
    @(negedge clk);
    idle_inputs();
    bus.RegW = 1'b1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
    #1;
    n_checks++;
    if (bus.RegWrite !== 1'b0) begin
      n_fail++; $display("FAIL ne_regwrite_held: got %b want 0", bus.RegWrite);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.Flags !== 4'b0100) begin
      n_fail++; $display("FAIL ne_flags_held: got %b want 0100", bus.Flags);
    end
  endtask

  task automatic test_nibble();
    @(negedge clk);
    idle_inputs();
    bus.CondLatch = 1'b1; bus.Cond = COND_AL; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0011;
    #1;
    n_checks++;
    if (bus.Flags !== 4'b0100) begin
      n_fail++; $display("FAIL flags_before_edge: got %b want 0100", bus.Flags);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.Flags !== 4'b0011) begin
      n_fail++; $display("FAIL flags_all_write: got %b want 0011", bus.Flags);
    end
    @(negedge clk);
    bus.FlagW = 2'b10; bus.ALUFlags = 4'b1011;
    @(posedge clk); #1;
    n_checks++;
    if (bus.Flags !== 4'b1011) begin
      n_fail++; $display("FAIL flags_nz_only: got %b want 1011", bus.Flags);
    end
    @(negedge clk);
    bus.FlagW = 2'b01; bus.ALUFlags = 4'b0100;
    @(posedge clk); #1;
    n_checks++;
    if (bus.Flags !== 4'b1000) begin
      n_fail++; $display("FAIL flags_cv_only: got %b want 1000", bus.Flags);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_pcwrite();
    @(negedge clk);
    idle_inputs();
    bus.CondLatch = 1'b1; bus.Cond = COND_NV; bus.PCS = 1'b1; bus.NextPC = 1'b0;
    #1;
    n_checks++;
    if (bus.PCWrite !== 1'b0) begin
      n_fail++; $display("FAIL nv_pcwrite: got %b want 0", bus.PCWrite);
    end
    bus.NextPC = 1'b1;
    #1;
    n_checks++;
    if (bus.PCWrite !== 1'b1) begin
      n_fail++; $display("FAIL nextpc_pcwrite: got %b want 1", bus.PCWrite);
    end
    bus.NextPC = 1'b0; bus.Cond = COND_AL; bus.MemW = 1'b1;
    #1;
    n_checks++;
    if (bus.PCWrite !== 1'b1) begin
      n_fail++; $display("FAIL al_pcwrite: got %b want 1", bus.PCWrite);
    end
    n_checks++;
    if (bus.MemWrite !== 1'b1) begin
      n_fail++; $display("FAIL al_memwrite: got %b want 1", bus.MemWrite);
    end
    // Flags=1000: MI passes, PL fails
    bus.Cond = COND_PL;
    #1;
    n_checks++;
    if (bus.PCWrite !== 1'b0) begin
      n_fail++; $display("FAIL pl_pcwrite: got %b want 0", bus.PCWrite);
    end
    bus.Cond = COND_MI;
    #1;
    n_checks++;
    if (bus.PCWrite !== 1'b1) begin
      n_fail++; $display("FAIL mi_pcwrite: got %b want 1", bus.PCWrite);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_cond_table();
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic exp_ok;
        chk_cond = 4'(c);
        chk_nzcv = 4'(f);
        exp_ok = ref_cond(4'(c), 4'(f));
        #1;
        n_checks++;
        if (chk_ok !== exp_ok) begin
          n_fail++;
          $display("FAIL cond_table cond=%b nzcv=%b: got %b want %b", chk_cond, chk_nzcv,
                   chk_ok, exp_ok);
        end
      end
    end
  endtask

`ifdef COND_BYPASS_EN
  task automatic test_bypass();
    // Flags=1000 (Z=0). Prior instruction latched AL so CondEx=1.
    @(negedge clk);
    idle_inputs();
    bus.CondLatch = 1'b1; bus.Cond = COND_AL;
    @(negedge clk);
    idle_inputs();
    bus.CondLatch = 1'b1; bus.Cond = COND_EQ; bus.FlagW = 2'b10; bus.ALUFlags = 4'b0100;
    bus.PCS = 1'b1;
    #1;
    n_checks++;
    if (bus.PCWrite !== 1'b1) begin
      n_fail++; $display("FAIL bypass_beq_pcwrite: got %b want 1", bus.PCWrite);
    end
    @(negedge clk);
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    chk_cond = 4'b0;
    chk_nzcv = 4'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_cond_eq();
    test_cond_fail();
    test_nibble();
    test_pcwrite();
    test_cond_table();
`ifdef COND_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
